avmm_lvds_bridge_req_arb: RTL and testbench

Packet-atomic round-robin arbiter that shares the single bridge request channel between the two Avalon slave request paths: port 0 (single-beat) and port 1 (burst). It forwards whole request packets from one requester at a time into the serializer-side request FIFO. It also keeps an in-order tag queue that records which requester owns each outstanding read, so the response path can route returning read data to the correct port. It sits between the slave-side request formatters and `req_data`/`req_valid` of the request channel.

---
 rtl/avmm_lvds_bridge_req_arb.sv | 138 +++++++++++++
 tb/tb_avmm_lvds_bridge_req_arb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_lvds_bridge_req_arb.sv
// Packet-atomic round-robin arbiter feeding the bridge request channel from the two slave paths,
// with an in-order tag queue that records the owner of each outstanding read.
module avmm_lvds_bridge_req_arb #(
   parameter int DATA_W    = 32,
   parameter int ORD_DEPTH = 8
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [DATA_W-1:0]            p0_data_i,
   input  logic                         p0_valid_i,
   input  logic                         p0_last_i,
   input  logic                         p0_rd_i,
   output logic                         p0_ready_o,
   input  logic [DATA_W-1:0]            p1_data_i,
   input  logic                         p1_valid_i,
   input  logic                         p1_last_i,
   input  logic                         p1_rd_i,
   output logic                         p1_ready_o,
   output logic [DATA_W-1:0]            req_data_o,
   output logic                         req_valid_o,
   input  logic                         req_ready_i,
   output logic                         ord_id_o,
   output logic                         ord_empty_o,
   input  logic                         ord_pop_i,
   output logic [$clog2(ORD_DEPTH):0]   ord_cnt_o
);

   // state | meaning
   // IDLE  | no packet in flight; arbitrate and grant one eligible port
   // XFER  | forwarding words of the granted port until its last word transfers
   typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

   localparam int PTR_W = $clog2(ORD_DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(ORD_DEPTH);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_grant;
   logic                  r_last_gnt;
   logic [ORD_DEPTH-1:0]  r_tag;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W:0]        r_cnt;

   logic w_full;
   logic w_empty;
   logic w_elig0;
   logic w_elig1;
   logic w_grant_en;
   logic w_grant_sel;
   logic w_push;
   logic w_pop;
   logic w_valid;
   logic w_last;

   assign w_full  = (r_cnt == CNT_FULL);
   assign w_empty = (r_cnt == '0);
   // Writes never wait on the tag queue; only reads need a free slot.
   assign w_elig0 = p0_valid_i & (~p0_rd_i | ~w_full);
   assign w_elig1 = p1_valid_i & (~p1_rd_i | ~w_full);
   assign w_pop   = ord_pop_i & ~w_empty;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_en  = 1'b0;
      w_grant_sel = r_grant;
      w_push      = 1'b0;
      w_valid     = 1'b0;
      w_last      = 1'b0;
      req_data_o  = '0;
      p0_ready_o  = 1'b0;
      p1_ready_o  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_elig0 | w_elig1) begin
               w_grant_en  = 1'b1;
               w_grant_sel = (w_elig0 & w_elig1) ? ~r_last_gnt : w_elig1;
               w_push      = w_grant_sel ? p1_rd_i : p0_rd_i;
               w_state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            req_data_o = r_grant ? p1_data_i  : p0_data_i;
            w_valid    = r_grant ? p1_valid_i : p0_valid_i;
            w_last     = r_grant ? p1_last_i  : p0_last_i;
            p0_ready_o = ~r_grant & req_ready_i;
            p1_ready_o = r_grant & req_ready_i;
            if (w_valid & req_ready_i & w_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign req_valid_o = w_valid;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state    <= ST_IDLE;
         r_grant    <= 1'b0;
         r_last_gnt <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant_en) begin
            r_grant    <= w_grant_sel;
            r_last_gnt <= w_grant_sel;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_tag    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_tag[r_wr_ptr] <= w_grant_sel;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign ord_empty_o = w_empty;
   assign ord_cnt_o   = r_cnt;
   assign ord_id_o    = w_empty ? 1'b0 : r_tag[r_rd_ptr];

endmodule

// File: tb/tb_avmm_lvds_bridge_req_arb.sv
// Scoreboard bench for the request arbiter: drivers queue expected channel words,
// a negedge monitor pops and compares every word the channel accepts.
module tb_avmm_lvds_bridge_req_arb;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [31:0] p0_data = '0;
   logic        p0_valid = 1'b0, p0_last = 1'b0, p0_rd = 1'b0;
   logic        p0_ready;
   logic [31:0] p1_data = '0;
   logic        p1_valid = 1'b0, p1_last = 1'b0, p1_rd = 1'b0;
   logic        p1_ready;
   logic [31:0] req_data;
   logic        req_valid;
   logic        req_ready = 1'b1;
   logic        ord_id, ord_empty;
   logic        ord_pop = 1'b0;
   logic [3:0]  ord_cnt;

   int          total = 0;
   int          bad = 0;
   logic        abort_drv = 1'b0;
   logic [31:0] exp_q[$];

   avmm_lvds_bridge_req_arb #(.DATA_W(32), .ORD_DEPTH(8)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .p0_data_i(p0_data), .p0_valid_i(p0_valid), .p0_last_i(p0_last), .p0_rd_i(p0_rd),
      .p0_ready_o(p0_ready),
      .p1_data_i(p1_data), .p1_valid_i(p1_valid), .p1_last_i(p1_last), .p1_rd_i(p1_rd),
      .p1_ready_o(p1_ready),
      .req_data_o(req_data), .req_valid_o(req_valid), .req_ready_i(req_ready),
      .ord_id_o(ord_id), .ord_empty_o(ord_empty), .ord_pop_i(ord_pop), .ord_cnt_o(ord_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && req_valid && req_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %0h want none at %0t", req_data, $time);
         end else begin
            chk("req_data", req_data, exp_q.pop_front());
         end
      end
   end

   task automatic send(input int port, input int n, input logic rd, input logic [31:0] base);
      int   cyc;
      logic rdy;
      for (int i = 0; i < n; i++) begin
         if (port == 0) begin
            p0_data = base + i; p0_valid = 1'b1; p0_last = (i == n-1); p0_rd = rd;
         end else begin
            p1_data = base + i; p1_valid = 1'b1; p1_last = (i == n-1); p1_rd = rd;
         end
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
            rdy = (port == 0) ? p0_ready : p1_ready;
         end while (!rdy && !abort_drv && cyc < 300);
         if (abort_drv) break;
         if (!rdy) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: port %0d word %0h got no ready want ready", port, base + i);
            break;
         end
         @(posedge clk); #1;
      end
      if (port == 0) begin
         p0_valid = 1'b0; p0_last = 1'b0; p0_rd = 1'b0;
      end else begin
         p1_valid = 1'b0; p1_last = 1'b0; p1_rd = 1'b0;
      end
   endtask

   task automatic do_reset();
      abort_drv = 1'b0;
      req_ready = 1'b1;
      ord_pop   = 1'b0;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic drain(input string nm);
      repeat (3) @(negedge clk);
      chk(nm, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int ids[4] = '{0, 1, 1, 0};
      // reset state, observed while reset is asserted
      #3 rstn = 1'b0;
      #1;
      chk("rst_req_valid", req_valid, 0);
      chk("rst_ord_empty", ord_empty, 1);
      chk("rst_ord_cnt", ord_cnt, 0);
      chk("rst_p0_ready", p0_ready, 0);
      chk("rst_p1_ready", p1_ready, 0);
      chk("rst_ord_id", ord_id, 0);
      do_reset();

      // single port-0 write: one-cycle grant latency, no tag
      exp_q.push_back(32'h0000_0100);
      fork
         send(0, 1, 1'b0, 32'h0000_0100);
         begin
            @(negedge clk);
            chk("t1_idle_valid", req_valid, 0);
            @(negedge clk);
            chk("t1_fwd_valid", req_valid, 1);
            chk("t1_cnt_mid", ord_cnt, 0);
         end
      join
      drain("t1_drain");
      chk("t1_cnt_end", ord_cnt, 0);

      // both ports continuously: 1-word p0 packets vs 4-word p1 packets alternate
      do_reset();
      exp_q.push_back(32'h0000_0100);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0200 + i);
      exp_q.push_back(32'h0000_0101);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0210 + i);
      fork
         begin
            send(0, 1, 1'b0, 32'h0000_0100);
            send(0, 1, 1'b0, 32'h0000_0101);
         end
         begin
            send(1, 4, 1'b0, 32'h0000_0200);
            send(1, 4, 1'b0, 32'h0000_0210);
         end
      join
      drain("t2_drain");

      // 16-word p1 burst under a toggling channel ready, p0 waiting behind it
      do_reset();
      for (int i = 0; i < 16; i++) exp_q.push_back(32'h0000_0300 + i);
      exp_q.push_back(32'h0000_0400);
      fork
         send(1, 16, 1'b0, 32'h0000_0300);
         begin
            @(posedge clk); #1;
            send(0, 1, 1'b0, 32'h0000_0400);
         end
         begin
            @(posedge clk); #1;
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               chk("t3_p1_ready_mirror", p1_ready, req_ready);
               chk("t3_p0_ready_blocked", p0_ready, 0);
               @(posedge clk); #1;
               req_ready = ~req_ready;
            end
            req_ready = 1'b1;
         end
      join
      drain("t3_drain");

      // tag queue full: 9th read holds, write passes, one pop releases the read
      do_reset();
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(32'h0000_0500 + i);
         send(0, 1, 1'b1, 32'h0000_0500 + i);
      end
      @(negedge clk);
      chk("t4_cnt_full", ord_cnt, 8);
      chk("t4_id_head", ord_id, 0);
      exp_q.push_back(32'h0000_0600);
      exp_q.push_back(32'h0000_0508);
      fork
         send(0, 1, 1'b1, 32'h0000_0508);
         send(1, 1, 1'b0, 32'h0000_0600);
         begin
            repeat (6) @(posedge clk);
            #1;
            @(negedge clk);
            chk("t4_cnt_held", ord_cnt, 8);
            chk("t4_read_held", req_valid, 0);
            @(posedge clk); #1;
            ord_pop = 1'b1;
            @(posedge clk); #1;
            ord_pop = 1'b0;
            @(negedge clk);
            chk("t4_cnt_after_pop", ord_cnt, 7);
            chk("t4_grant_cycle_valid", req_valid, 0);
            @(negedge clk);
            chk("t4_read_released", req_valid, 1);
         end
      join
      drain("t4_drain");
      chk("t4_cnt_refill", ord_cnt, 8);

      // interleaved read owners then pops
      do_reset();
      exp_q.push_back(32'h0000_0700);
      exp_q.push_back(32'h0000_0701);
      exp_q.push_back(32'h0000_0702);
      exp_q.push_back(32'h0000_0703);
      send(0, 1, 1'b1, 32'h0000_0700);
      send(1, 1, 1'b1, 32'h0000_0701);
      send(1, 1, 1'b1, 32'h0000_0702);
      send(0, 1, 1'b1, 32'h0000_0703);
      drain("t5_drain");
      chk("t5_cnt4", ord_cnt, 4);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_ord_id", ord_id, ids[i]);
         chk("t5_not_empty", ord_empty, 0);
         @(posedge clk); #1;
         ord_pop = 1'b1;
         @(posedge clk); #1;
         ord_pop = 1'b0;
      end
      @(negedge clk);
      chk("t5_empty", ord_empty, 1);
      chk("t5_cnt0", ord_cnt, 0);
      @(posedge clk); #1;
      ord_pop = 1'b1;
      @(posedge clk); #1;
      ord_pop = 1'b0;
      @(negedge clk);
      chk("t5_pop_empty_cnt", ord_cnt, 0);
      chk("t5_pop_empty_flag", ord_empty, 1);

      // asynchronous reset mid-burst, then port 0 wins first
      do_reset();
      exp_q.push_back(32'h0000_0800);
      send(0, 1, 1'b1, 32'h0000_0800);
      exp_q.push_back(32'h0000_0900);
      exp_q.push_back(32'h0000_0901);
      fork
         send(1, 4, 1'b0, 32'h0000_0900);
         begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            @(negedge clk);
            #2 rstn = 1'b0;
            #1;
            chk("t6_rst_valid", req_valid, 0);
            chk("t6_rst_data", req_data, 0);
            chk("t6_rst_p1_ready", p1_ready, 0);
            chk("t6_rst_empty", ord_empty, 1);
            chk("t6_rst_cnt", ord_cnt, 0);
            abort_drv = 1'b1;
            @(negedge clk);
            @(negedge clk);
            #2 rstn = 1'b1;
            abort_drv = 1'b0;
         end
      join
      chk("t6_sb_partial", exp_q.size(), 0);
      @(posedge clk); #1;
      exp_q.push_back(32'h0000_0A00);
      exp_q.push_back(32'h0000_0A01);
      fork
         send(0, 1, 1'b0, 32'h0000_0A00);
         send(1, 1, 1'b0, 32'h0000_0A01);
      join
      drain("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
